ifu_fetch_queue: RTL and testbench
==================================

// Module: ifu_fetch_queue
// PURPOSE
//  Fetch stage directly downstream of the PC/branch-predict stage. It takes each fetch
//  address and its predict-taken flag, and issues the address to instruction memory over a
//  req/gnt + rvalid bus that may have variable latency. It tracks in-flight requests and
//  buffers returned instructions in order. The instruction, its PC and its prediction go to
//  decode over a valid/ready handshake. A flush (any jump cause) discards all queued and
//  in-flight work.
// PARAMETERS
//  DEPTH   4   max in-flight + buffered instructions; power of 2, >=2
//  ADDR_W  32  instruction address width
//  DATA_W  32  instruction width
// PORTS
//  clk            in   1       clock, all logic on posedge
//  rst_n          in   1       synchronous reset, active-high (reset when rst_n==1'b1)
//  fetch_valid_i  in   1       PC stage offers an address
//  fetch_addr_i   in   ADDR_W  fetch address from PC stage
//  fetch_pred_i   in   1       PC stage predicted a taken branch into this address
//  fetch_ready_o  out  1       address accepted this cycle
//  flush_i        in   1       jump_cause != none; kill everything younger
//  imem_req_o     out  1       memory request
//  imem_addr_o    out  ADDR_W  memory address (== fetch_addr_i)
//  imem_gnt_i     in   1       memory accepts request this cycle
//  imem_rvalid_i  in   1       response data valid, in request order
//  imem_rdata_i   in   DATA_W  response instruction
//  id_valid_o     out  1       instruction available to decode
//  id_ready_i     in   1       decode consumes (hold = !id_ready_i)
//  id_inst_o      out  DATA_W  instruction
//  id_pc_o        out  ADDR_W  its address
//  id_pred_o      out  1       its fetch_pred_i
// BEHAVIOUR
//  - State: tag FIFO {addr,pred} of in-flight requests (DEPTH entries); data FIFO
//    {inst,addr,pred} (DEPTH entries); outstanding cnt; discard cnt (0..DEPTH).
//  - Credit: credit = (outstanding + data_count + discard) < DEPTH.
//    Decode pops free credit the next cycle, not combinationally.
//  - imem_req_o = fetch_valid_i & credit & !flush_i.
//  - fetch_ready_o = imem_req_o & imem_gnt_i.
//  - On fetch_ready_o: push {addr,pred} to tag FIFO; outstanding+1.
//  - On imem_rvalid_i with discard>0: drop the data; discard-1. No tag pop.
//  - Else on rvalid with outstanding>0: pop tag FIFO, push {rdata,tag} to data FIFO,
//    outstanding-1.
//  - Else rvalid with outstanding==0: ignore; no state change.
//  - Latency: rvalid in cycle N gives id_valid_o=1 in N+1 (registered, no bypass).
//  - id_valid_o = data FIFO not empty. id_* show the head entry.
//  - Pop the head when id_valid_o & id_ready_i. id_* hold stable while valid & !ready.
//  - Flush (highest priority) in cycle N:
//    - No request issued (imem_req_o=0).
//    - Data FIFO and tag FIFO emptied at N+1.
//    - discard <= discard + outstanding, less 1 if rvalid in N.
//    - outstanding <= 0.
//    - An id pop in N has no effect.
//    - id_valid_o=0 from N+1 until new, non-discarded data returns.
//  - Simultaneous grant and response in one cycle: both counters update, net outstanding
//    unchanged. Simultaneous push and pop on the data FIFO is legal at any fill level.
//  - Pointers wrap modulo DEPTH; FIFO full and empty are distinguished by count.
//  - Reset (including mid-burst):
//    - All counters, pointers and FIFOs cleared.
//    - id_valid_o=0, imem_req_o=0, fetch_ready_o=0.
//    - id_inst_o=0, id_pc_o=0, id_pred_o=0, imem_addr_o=fetch_addr_i.
//    - Responses to pre-reset requests are the memory's problem; bus must be quiesced.
//  - Assertions: data FIFO never overflows; outstanding+data_count+discard <= DEPTH.
// TESTING
//  1. Zero-wait memory (gnt=1, rvalid one cycle after grant), addrs 0x0,0x4,0x8, ready=1
//     -> id_pc_o 0x0,0x4,0x8 in consecutive cycles, first id_valid 2 cycles after first req.
//  2. id_ready_i=0, memory always ready -> exactly 4 requests granted, then
//     fetch_ready_o=0. Set ready=1 -> drains in order; a new req the cycle after the 1st pop.
//  3. 3 requests outstanding (latency 5), flush_i in one cycle, then fetch 0x100
//     -> 3 old responses dropped; first id output is pc 0x100 with its rdata.
//  4. Flush in same cycle as an rvalid and an id pop -> that response dropped, discard
//     == outstanding-1, no id output until post-flush data.
//  5. fetch_pred_i=1 on 0x20 only -> id_pred_o=1 only with id_pc_o=0x20.
//  6. Assert rst_n=1 with 2 buffered + 2 in flight -> next cycle id_valid_o=0,
//     counters 0; first fetch after reset (0x0) returns normally.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// Fetch stage: issues PCs to imem over req/gnt + rvalid and buffers the
// returned instructions in order for decode; flush discards in-flight work.
module ifu_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  input  logic              fetch_pred_i,
  output logic              fetch_ready_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [DATA_W-1:0] id_inst_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic              id_pred_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  logic [ADDR_W-1:0] tag_addr_q [DEPTH];
  logic [DEPTH-1:0]  tag_pred_q;
  logic [PW-1:0]     tag_wp_q;
  logic [PW-1:0]     tag_rp_q;

  logic [DATA_W-1:0] dq_inst_q [DEPTH];
  logic [ADDR_W-1:0] dq_pc_q [DEPTH];
  logic [DEPTH-1:0]  dq_pred_q;
  logic [PW-1:0]     dq_wp_q;
  logic [PW-1:0]     dq_rp_q;

  logic [CW-1:0] dq_cnt_q, dq_cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;

  logic [SW-1:0] used;
  logic          credit;
  logic          drop;
  logic          resp;
  logic          pop;
  logic          any_pend;

  // Credit covers every slot a response could still land in.
  assign used   = SW'(out_q) + SW'(dq_cnt_q) + SW'(disc_q);
  assign credit = used < SW'(DEPTH);

  assign imem_req_o    = fetch_valid_i & credit & ~flush_i & ~rst_n;
  assign fetch_ready_o = imem_req_o & imem_gnt_i;
  assign imem_addr_o   = fetch_addr_i;

  assign id_valid_o = (dq_cnt_q != '0) & ~rst_n;
  assign id_inst_o  = id_valid_o ? dq_inst_q[dq_rp_q] : '0;
  assign id_pc_o    = id_valid_o ? dq_pc_q[dq_rp_q] : '0;
  assign id_pred_o  = id_valid_o & dq_pred_q[dq_rp_q];

  assign drop     = imem_rvalid_i & (disc_q != '0);
  assign resp     = imem_rvalid_i & ~drop & (out_q != '0);
  assign pop      = id_valid_o & id_ready_i;
  assign any_pend = (disc_q != '0) | (out_q != '0);

  always_comb begin
    out_d    = out_q;
    disc_d   = disc_q;
    dq_cnt_d = dq_cnt_q;
    if (flush_i) begin
      out_d    = '0;
      dq_cnt_d = '0;
      disc_d   = disc_q + out_q
               - CW'(imem_rvalid_i & any_pend);
    end else begin
      out_d    = out_q + CW'(fetch_ready_o) - CW'(resp);
      disc_d   = disc_q - CW'(drop);
      dq_cnt_d = dq_cnt_q + CW'(resp) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_q    <= '0;
      disc_q   <= '0;
      dq_cnt_q <= '0;
      tag_wp_q <= '0;
      tag_rp_q <= '0;
      dq_wp_q  <= '0;
      dq_rp_q  <= '0;
    end else begin
      out_q    <= out_d;
      disc_q   <= disc_d;
      dq_cnt_q <= dq_cnt_d;
      if (flush_i) begin
        tag_wp_q <= '0;
        tag_rp_q <= '0;
        dq_wp_q  <= '0;
        dq_rp_q  <= '0;
      end else begin
        if (fetch_ready_o) tag_wp_q <= tag_wp_q + PW'(1);
        if (resp) begin
          tag_rp_q <= tag_rp_q + PW'(1);
          dq_wp_q  <= dq_wp_q + PW'(1);
        end
        if (pop) dq_rp_q <= dq_rp_q + PW'(1);
      end
    end
  end

  // Storage needs no reset: every read is qualified by a count.
  always_ff @(posedge clk) begin
    if (fetch_ready_o) begin
      tag_addr_q[tag_wp_q] <= fetch_addr_i;
      tag_pred_q[tag_wp_q] <= fetch_pred_i;
    end
    if (resp) begin
      dq_inst_q[dq_wp_q] <= imem_rdata_i;
      dq_pc_q[dq_wp_q]   <= tag_addr_q[tag_rp_q];
      dq_pred_q[dq_wp_q] <= tag_pred_q[tag_rp_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      assert (!(resp && !pop && dq_cnt_q == CW'(DEPTH)));
      assert (used <= SW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: variable-latency imem model plus
// an in-order scoreboard of {pred,pc,inst} checked on every decode pop.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_pred_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic        id_pred_o;

  typedef struct {
    logic        pred;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mem_q[$];
  int    cyc = 0;
  int    lat = 1;
  int    errs = 0;
  int    checks = 0;
  int    got;

  ifu_fetch_queue dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid_i(fetch_valid_i), .fetch_addr_i(fetch_addr_i),
    .fetch_pred_i(fetch_pred_i), .fetch_ready_o(fetch_ready_o),
    .flush_i(flush_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_inst_o(id_inst_o), .id_pc_o(id_pc_o), .id_pred_o(id_pred_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] minst(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // imem: answers in order, lat cycles after the grant
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = minst(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
  end

  // scoreboard: push on grant, pop and compare on decode handshake
  always @(negedge clk) begin
    exp_t e;
    mreq_t m;
    if (rst_n) begin
      exp_q.delete();
      mem_q.delete();
    end else begin
      if (fetch_ready_o) begin
        e.pred = fetch_pred_i;
        e.pc   = fetch_addr_i;
        e.inst = minst(fetch_addr_i);
        exp_q.push_back(e);
        m.addr = fetch_addr_i;
        m.due  = cyc + lat;
        mem_q.push_back(m);
      end
      if (flush_i) begin
        exp_q.delete();
      end else if (id_valid_o && id_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pop", id_pc_o, 64'hFFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", id_pc_o, e.pc);
          chk("sb_inst", id_inst_o, e.inst);
          chk("sb_pred", id_pred_o, e.pred);
        end
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_n(input logic [31:0] a0, input int n,
                         input logic [31:0] pa, input int maxc,
                         output int g);
    logic [31:0] a;
    a = a0;
    g = 0;
    fetch_valid_i = 1'b1;
    fetch_addr_i  = a;
    fetch_pred_i  = (a == pa);
    for (int i = 0; i < maxc && g < n; i++) begin
      @(negedge clk);
      if (fetch_ready_o) begin
        g++;
        a = a + 32'd4;
      end
      nxt();
      fetch_valid_i = (g < n);
      fetch_addr_i  = a;
      fetch_pred_i  = (a == pa);
    end
    fetch_valid_i = 1'b0;
    fetch_pred_i  = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = id_valid_o;
      if (!seen) nxt();
    end
    chk(tag, seen, 1);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (mem_q.size() == 0)
          && !id_valid_o && !imem_rvalid_i;
      nxt();
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    fetch_valid_i = 1'b0;
    fetch_addr_i = '0;
    fetch_pred_i = 1'b0;
    flush_i = 1'b0;
    imem_gnt_i = 1'b1;
    id_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    fetch_valid_i = 1'b1;
    fetch_addr_i  = 32'h1234;
    @(negedge clk);
    chk("rst_req", imem_req_o, 0);
    chk("rst_frdy", fetch_ready_o, 0);
    chk("rst_idv", id_valid_o, 0);
    chk("rst_addr", imem_addr_o, 32'h1234);
    nxt();
    rst_n = 1'b0;
    fetch_valid_i = 1'b0;
    @(negedge clk);
    chk("idle_idv", id_valid_o, 0);
    chk("idle_pc", id_pc_o, 0);
    chk("idle_inst", id_inst_o, 0);
    nxt();

    // T1: zero-wait memory, back-to-back
    lat = 1;
    for (int i = 0; i < 6; i++) begin
      fetch_valid_i = (i < 3);
      fetch_addr_i  = 32'(4 * i);
      @(negedge clk);
      if (i < 3) chk("t1_grant", fetch_ready_o, 1);
      chk("t1_valid", id_valid_o, (i >= 2 && i <= 4));
      if (i >= 2 && i <= 4) chk("t1_pc", id_pc_o, 32'(4 * (i - 2)));
      nxt();
    end
    fetch_valid_i = 1'b0;
    drain("t1_drain");

    // T2: decode stalled, credit limit, then drain
    id_ready_i = 1'b0;
    fetch_n(32'h400, 8, 32'hFFFF_FFFF, 10, got);
    chk("t2_grants", got, 4);
    @(negedge clk);
    chk("t2_hold_v", id_valid_o, 1);
    chk("t2_hold_pc0", id_pc_o, 32'h400);
    nxt();
    @(negedge clk);
    chk("t2_hold_pc1", id_pc_o, 32'h400);
    nxt();
    fetch_valid_i = 1'b1;
    fetch_addr_i  = 32'h410;
    id_ready_i    = 1'b1;
    @(negedge clk);
    chk("t2_pop_frdy", fetch_ready_o, 0);
    chk("t2_pop_pc", id_pc_o, 32'h400);
    nxt();
    @(negedge clk);
    chk("t2_refill_frdy", fetch_ready_o, 1);
    nxt();
    fetch_valid_i = 1'b0;
    drain("t2_drain");

    // T3: flush with three requests in flight
    lat = 5;
    fetch_n(32'h40, 3, 32'hFFFF_FFFF, 10, got);
    chk("t3_grants", got, 3);
    flush_i = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_addr_i  = 32'h80;
    @(negedge clk);
    chk("t3_flush_req", imem_req_o, 0);
    chk("t3_flush_rv", imem_rvalid_i, 0);
    nxt();
    flush_i = 1'b0;
    fetch_n(32'h100, 1, 32'hFFFF_FFFF, 10, got);
    wait_valid("t3_wait");
    chk("t3_pc", id_pc_o, 32'h100);
    chk("t3_inst", id_inst_o, minst(32'h100));
    nxt();
    drain("t3_drain");

    // T4: flush coinciding with rvalid and a decode pop
    lat = 3;
    fetch_n(32'h200, 4, 32'hFFFF_FFFF, 10, got);
    chk("t4_grants", got, 4);
    flush_i = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_addr_i  = 32'h210;
    @(negedge clk);
    chk("t4_rv", imem_rvalid_i, 1);
    chk("t4_idv", id_valid_o, 1);
    chk("t4_req", imem_req_o, 0);
    nxt();
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    @(negedge clk);
    chk("t4_post_idv", id_valid_o, 0);
    nxt();
    fetch_n(32'h300, 1, 32'hFFFF_FFFF, 10, got);
    wait_valid("t4_wait");
    chk("t4_pc", id_pc_o, 32'h300);
    nxt();
    drain("t4_drain");

    // T5: prediction flag follows only its own PC
    lat = 1;
    fetch_n(32'h18, 4, 32'h20, 10, got);
    chk("t5_grants", got, 4);
    drain("t5_drain");

    // T6: reset with 2 buffered and 2 in flight
    lat = 4;
    id_ready_i = 1'b0;
    fetch_n(32'h500, 4, 32'hFFFF_FFFF, 10, got);
    chk("t6_grants", got, 4);
    nxt();
    @(negedge clk);
    chk("t6_buffered", id_valid_o, 1);
    nxt();
    rst_n = 1'b1;
    nxt();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_idv", id_valid_o, 0);
    chk("t6_pc", id_pc_o, 0);
    chk("t6_inst", id_inst_o, 0);
    chk("t6_pred", id_pred_o, 0);
    nxt();
    lat = 1;
    fetch_n(32'h0, 8, 32'hFFFF_FFFF, 10, got);
    chk("t6_credit", got, 4);
    @(negedge clk);
    chk("t6_first_pc", id_pc_o, 0);
    nxt();
    id_ready_i = 1'b1;
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
